fir_requant_decim: RTL and testbench
====================================

// Module: fir_requant_decim
// PURPOSE
//   Post-FIR output stage for the audio path. Consumes the full-precision signed
//   FIR accumulator stream (one sample per din_valid) and keeps every DECIM-th sample.
//   Each kept sample is rounded, right-shifted by SHIFT, saturated to OUT_WIDTH, and
//   buffered in a small FIFO. The FIFO feeds the I2S transmit side over a valid/ready
//   handshake. Overflow and clipping are reported.
// PARAMETERS
//   IN_WIDTH    32  signed input width (FIR accumulator)
//   OUT_WIDTH   16  signed output sample width
//   SHIFT       15  arithmetic right shift applied after rounding (Q15 coefficients)
//   DECIM        4  decimation factor, >=1 (1 = pass every sample)
//   FIFO_DEPTH   4  output FIFO entries, power of two, >=2
// PORTS
//   clk           in   1          clock
//   resetn        in   1          synchronous, active-low reset
//   din           in   IN_WIDTH   signed FIR output sample
//   din_valid     in   1          din qualifier; tie high for a free-running FIR
//   m_tdata       out  OUT_WIDTH  signed requantised sample (FIFO head)
//   m_tvalid      out  1          m_tdata valid
//   m_tready      in   1          downstream accepts when m_tvalid && m_tready
//   clip          out  1          1-cycle pulse: sample saturated at stage 2
//   overflow      out  1          sticky: a sample was dropped on a full FIFO
//   overflow_clr  in   1          clears overflow
// BEHAVIOUR
//   Reset (resetn=0 at a clk edge) clears these to 0: phase counter, pipeline valids,
//     FIFO pointers/count, m_tvalid, m_tdata, clip and overflow. Reset mid-operation
//     discards all in-flight and buffered samples. No output handshake occurs in the
//     cycle after reset.
//   Phase: phase counts 0..DECIM-1 on each din_valid and wraps to 0 after DECIM-1.
//     The sample is kept when din_valid && phase==DECIM-1, so the first kept sample is
//     the DECIM-th valid sample after reset. When din_valid=0, phase holds.
//   Stage 1 (edge E0, kept sample): r1 <= (sext(din,IN_WIDTH+1) + 2^(SHIFT-1)) >>> SHIFT.
//     The sum is formed in IN_WIDTH+1 bits so it never wraps. Rounding is half-up
//     (toward +inf at exact .5). r1 is IN_WIDTH+1-SHIFT bits wide.
//   Stage 2 (E1): r2 <= r1 clamped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
//     clip is high in the cycle after E1 iff the clamp was active.
//   FIFO write (E2): r2 is pushed. Latency is 3 edges: a sample kept at E0 is first
//     visible on m_tdata/m_tvalid in the cycle after E2 when the FIFO was empty.
//   Pipeline: fully pipelined. It accepts a kept sample every cycle and never stalls
//     upstream. The FIR cannot be back-pressured.
//   FIFO full: a push is dropped and overflow is set. Stored data and order are unchanged.
//   Full + pop in the same cycle: the pop frees a slot and the push is accepted.
//     No drop occurs and overflow is not set.
//   Empty + push: m_tvalid is 0 that cycle and 1 from the next cycle. There is no
//     same-cycle fall-through.
//   Empty + pop: ignored. m_tvalid=0; m_tdata is not required to be meaningful.
//   Handshake: m_tvalid stays high and m_tdata stays stable until accepted. The pointer
//     advances only on m_tvalid && m_tready.
//   overflow_clr: clears overflow. If set and clear occur in the same cycle, set wins.
//   Pointers wrap modulo FIFO_DEPTH. Count is in 0..FIFO_DEPTH; full = count==FIFO_DEPTH.
// TESTING
//   1 Rounding, DECIM=1, m_tready=1: din=0x00004000 -> 0x0001; 0x00003FFF -> 0x0000;
//     0xFFFFC000 -> 0x0000; 0xFFFFBFFF -> 0xFFFF. Each appears 3 edges after input.
//   2 Saturation: din=0x40000000 -> 0x7FFF with clip pulse; din=0x80000000 -> 0x8000
//     with clip pulse; din=0x3FFF0000 -> 0x7FFE with no clip.
//   3 Decimation, DECIM=4, din_valid=1, din=n<<15 for n=0,1,2,...
//     -> outputs 3,7,11,15 in order. With din_valid toggling 1/0, outputs are identical.
//   4 Backpressure, m_tready=0: five kept samples 1..5 -> FIFO holds 1..4, 5 is dropped,
//     overflow=1. Then m_tready=1 -> 1,2,3,4 drained, then m_tvalid=0.
//   5 Full + simultaneous pop/push: with FIFO full, pop on the same edge as push of 9
//     -> no drop, overflow stays 0, and 9 is read last.
//   6 Reset mid-stream: resetn=0 for 1 edge with 3 samples buffered and 2 in flight
//     -> m_tvalid=0, overflow=0. The next output is the 4th valid input after reset.

Source files
------------

// File: rtl/fir_requant_decim.sv
// fir_requant_decim
//   Post-FIR output stage for the audio path. Keeps every DECIM-th valid
//   accumulator sample, rounds it half-up, shifts right by SHIFT, saturates
//   to OUT_WIDTH and queues it in a small FIFO read over valid/ready.
//
//   clk           clock
//   resetn        synchronous active-low reset
//   din           signed FIR accumulator sample (IN_WIDTH)
//   din_valid     din qualifier
//   m_tdata       signed requantised sample at the FIFO head (OUT_WIDTH)
//   m_tvalid      m_tdata valid
//   m_tready      downstream accept
//   clip          one-cycle pulse when a sample was saturated
//   overflow      sticky: a sample was dropped because the FIFO was full
//   overflow_clr  clears overflow (a simultaneous new drop wins)
module fir_requant_decim #(
    parameter int IN_WIDTH   = 32,
    parameter int OUT_WIDTH  = 16,
    parameter int SHIFT      = 15,
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [IN_WIDTH-1:0]  din,
    input  logic                 din_valid,
    output logic [OUT_WIDTH-1:0] m_tdata,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic                 clip,
    output logic                 overflow,
    input  logic                 overflow_clr
);

    localparam int PW  = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int R1W = IN_WIDTH + 1 - SHIFT;
    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = AW + 1;

    localparam logic [PW-1:0] PH_LAST = PW'(DECIM - 1);
    localparam logic signed [IN_WIDTH:0] RND =
        {{(IN_WIDTH - SHIFT + 1){1'b0}}, 1'b1, {(SHIFT - 1){1'b0}}};
    localparam logic signed [R1W-1:0] SAT_MAX =
        {{(R1W - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [R1W-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH - 1){1'b0}}};

    logic [PW-1:0]          phase_q, phase_d;
    logic                   keep;
    logic signed [IN_WIDTH:0] sum;
    logic                   unused_lsb;
    logic                   v1_q, v2_q;
    logic signed [R1W-1:0]  r1_q;
    logic [OUT_WIDTH-1:0]   r2_q, r2_d;
    logic                   clip_q, clip_d;
    logic [OUT_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]          count_q;
    logic                   overflow_q;
    logic                   full, pop, push_ok, drop;

    // Decimation phase: advances only on valid input.
    assign keep = din_valid && (phase_q == PH_LAST);

    always_comb begin
        phase_d = phase_q;
        if (din_valid) begin
            phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PW'(1);
        end
    end

    // One extra bit of headroom so adding the rounding constant never wraps;
    // taking the upper bits of the sum is the arithmetic shift.
    assign sum        = $signed({din[IN_WIDTH-1], din}) + RND;
    assign unused_lsb = ^sum[SHIFT-1:0];

    always_comb begin
        r2_d   = r1_q[OUT_WIDTH-1:0];
        clip_d = 1'b0;
        if (r1_q > SAT_MAX) begin
            r2_d   = OUT_MAX;
            clip_d = v1_q;
        end else if (r1_q < SAT_MIN) begin
            r2_d   = OUT_MIN;
            clip_d = v1_q;
        end
    end

    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign pop     = m_tvalid && m_tready;
    assign push_ok = v2_q && (!full || pop);
    assign drop    = v2_q && full && !pop;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            phase_q    <= '0;
            v1_q       <= 1'b0;
            r1_q       <= '0;
            v2_q       <= 1'b0;
            r2_q       <= '0;
            clip_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            v1_q    <= keep;
            if (keep) begin
                r1_q <= sum[IN_WIDTH:SHIFT];
            end
            v2_q   <= v1_q;
            r2_q   <= r2_d;
            clip_q <= clip_d;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(push_ok) - CW'(pop);
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (overflow_clr) begin
                overflow_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && push_ok) begin
            mem_q[wr_ptr_q] <= r2_q;
        end
    end

    assign m_tvalid = (count_q != '0);
    assign m_tdata  = m_tvalid ? mem_q[rd_ptr_q] : '0;
    assign clip     = clip_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_fir_requant_decim.sv
module tb_fir_requant_decim;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] din = '0;
    logic        din_valid = 1'b0;
    logic        m_tready = 1'b0;
    logic        overflow_clr = 1'b0;

    logic [15:0] m_tdata1, m_tdata4;
    logic        m_tvalid1, m_tvalid4, clip1, clip4, overflow1, overflow4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fir_requant_decim #(.DECIM(1)) dut1 (
        .clk(clk), .resetn(resetn), .din(din), .din_valid(din_valid),
        .m_tdata(m_tdata1), .m_tvalid(m_tvalid1), .m_tready(m_tready),
        .clip(clip1), .overflow(overflow1), .overflow_clr(overflow_clr)
    );

    fir_requant_decim #(.DECIM(4)) dut4 (
        .clk(clk), .resetn(resetn), .din(din), .din_valid(din_valid),
        .m_tdata(m_tdata4), .m_tvalid(m_tvalid4), .m_tready(m_tready),
        .clip(clip4), .overflow(overflow4), .overflow_clr(overflow_clr)
    );

    typedef struct {
        string       name;
        logic [31:0] din;
        logic [15:0] exp_data;
        logic        exp_clip;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        din_valid    = 1'b0;
        din          = '0;
        overflow_clr = 1'b0;
        resetn       = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    // Feed n values (value k<<15 for k in seq) on dut4 stream and collect dut4 outputs.
    logic [15:0] q4[$];
    logic [15:0] q1[$];

    initial begin
        vecs[0] = '{"rnd_half_up",   32'h0000_4000, 16'h0001, 1'b0};
        vecs[1] = '{"rnd_below",     32'h0000_3FFF, 16'h0000, 1'b0};
        vecs[2] = '{"rnd_neg_half",  32'hFFFF_C000, 16'h0000, 1'b0};
        vecs[3] = '{"rnd_neg_below", 32'hFFFF_BFFF, 16'hFFFF, 1'b0};
        vecs[4] = '{"sat_pos",       32'h4000_0000, 16'h7FFF, 1'b1};
        vecs[5] = '{"sat_neg",       32'h8000_0000, 16'h8000, 1'b1};
        vecs[6] = '{"near_pos",      32'h3FFF_0000, 16'h7FFE, 1'b0};

        tick();
        do_reset();
        chk("reset_tvalid1",   {31'd0, m_tvalid1}, 32'd0);
        chk("reset_tdata1",    {16'd0, m_tdata1},  32'd0);
        chk("reset_clip1",     {31'd0, clip1},     32'd0);
        chk("reset_overflow1", {31'd0, overflow1}, 32'd0);
        chk("reset_tvalid4",   {31'd0, m_tvalid4}, 32'd0);
        chk("reset_overflow4", {31'd0, overflow4}, 32'd0);

        // Rounding and saturation through the DECIM=1 instance.
        m_tready = 1'b1;
        foreach (vecs[i]) begin
            din = vecs[i].din;
            din_valid = 1'b1;
            tick();                                  // E0
            din_valid = 1'b0;
            din = '0;
            tick();                                  // E1
            chk({vecs[i].name, "_clip"}, {31'd0, clip1}, {31'd0, vecs[i].exp_clip});
            chk({vecs[i].name, "_early"}, {31'd0, m_tvalid1}, 32'd0);
            tick();                                  // E2
            chk({vecs[i].name, "_valid"}, {31'd0, m_tvalid1}, 32'd1);
            chk({vecs[i].name, "_data"}, {16'd0, m_tdata1}, {16'd0, vecs[i].exp_data});
            chk({vecs[i].name, "_clip_gone"}, {31'd0, clip1}, 32'd0);
            tick();
            chk({vecs[i].name, "_drained"}, {31'd0, m_tvalid1}, 32'd0);
        end

        // Decimation, continuous valid.
        do_reset();
        m_tready = 1'b1;
        q4.delete();
        for (int c = 0; c < 24; c++) begin
            din_valid = (c < 16);
            din = 32'(c) << 15;
            tick();
            if (m_tvalid4) q4.push_back(m_tdata4);
        end
        chk("decim_count", q4.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("decim_data", (i < q4.size()) ? {16'd0, q4[i]} : 32'hDEAD, 32'(4 * i + 3));
        end

        // Decimation, valid toggling: phase must hold on idle cycles.
        do_reset();
        m_tready = 1'b1;
        q4.delete();
        for (int c = 0; c < 40; c++) begin
            din_valid = (c < 32) && (c % 2 == 0);
            din = 32'(c / 2) << 15;
            tick();
            if (m_tvalid4) q4.push_back(m_tdata4);
        end
        chk("decim_toggle_count", q4.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("decim_toggle_data", (i < q4.size()) ? {16'd0, q4[i]} : 32'hDEAD, 32'(4 * i + 3));
        end

        // Backpressure and overflow on DECIM=1; clear held high across the drop edge.
        do_reset();
        m_tready = 1'b0;
        overflow_clr = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            din = 32'(k) << 15;
            din_valid = 1'b1;
            tick();
        end
        din_valid = 1'b0;
        tick();
        chk("bp_no_overflow_yet", {31'd0, overflow1}, 32'd0);
        tick();                                      // 5th sample dropped here
        overflow_clr = 1'b0;
        chk("bp_set_wins", {31'd0, overflow1}, 32'd1);
        tick();
        chk("bp_overflow_sticky", {31'd0, overflow1}, 32'd1);
        chk("bp_head", {16'd0, m_tdata1}, 32'd1);
        tick();
        chk("bp_head_stable", {16'd0, m_tdata1}, 32'd1);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        chk("bp_overflow_clr", {31'd0, overflow1}, 32'd0);
        m_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_drain_valid", {31'd0, m_tvalid1}, 32'd1);
            chk("bp_drain_data", {16'd0, m_tdata1}, 32'(i + 1));
            tick();
        end
        chk("bp_empty", {31'd0, m_tvalid1}, 32'd0);

        // Full FIFO with pop and push on the same edge.
        do_reset();
        m_tready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            din = 32'(k) << 15;
            din_valid = 1'b1;
            tick();
        end
        din_valid = 1'b0;
        tick();
        tick();
        tick();
        din = 32'(9) << 15;
        din_valid = 1'b1;
        tick();                                      // E0
        din_valid = 1'b0;
        tick();                                      // E1
        m_tready = 1'b1;
        tick();                                      // E2: pop 1, push 9
        m_tready = 1'b0;
        chk("fullpop_overflow", {31'd0, overflow1}, 32'd0);
        chk("fullpop_head", {16'd0, m_tdata1}, 32'd2);
        m_tready = 1'b1;
        q1.delete();
        for (int c = 0; c < 8; c++) begin
            if (m_tvalid1) q1.push_back(m_tdata1);
            tick();
        end
        chk("fullpop_count", q1.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("fullpop_order", (i < q1.size()) ? {16'd0, q1[i]} : 32'hDEAD,
                (i == 3) ? 32'd9 : 32'(i + 2));
        end

        // Reset mid-stream: 3 buffered + 2 in flight on dut1, one in flight on dut4.
        do_reset();
        m_tready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            din = 32'(k) << 15;
            din_valid = 1'b1;
            tick();
        end
        chk("mid_buffered", {31'd0, m_tvalid1}, 32'd1);
        do_reset();
        chk("mid_tvalid1", {31'd0, m_tvalid1}, 32'd0);
        chk("mid_overflow1", {31'd0, overflow1}, 32'd0);
        chk("mid_tvalid4", {31'd0, m_tvalid4}, 32'd0);
        for (int c = 0; c < 4; c++) tick();
        chk("mid_flight_gone1", {31'd0, m_tvalid1}, 32'd0);
        chk("mid_flight_gone4", {31'd0, m_tvalid4}, 32'd0);
        m_tready = 1'b1;
        q1.delete();
        q4.delete();
        for (int c = 0; c < 12; c++) begin
            din_valid = (c < 4);
            din = 32'(11 + c) << 15;
            tick();
            if (m_tvalid1) q1.push_back(m_tdata1);
            if (m_tvalid4) q4.push_back(m_tdata4);
        end
        chk("mid_first1", (q1.size() > 0) ? {16'd0, q1[0]} : 32'hDEAD, 32'd11);
        chk("mid_count4", q4.size(), 1);
        chk("mid_first4", (q4.size() > 0) ? {16'd0, q4[0]} : 32'hDEAD, 32'd14);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
